// File: rtl/pc_redirect_ctrl_if.sv
// rtl/pc_redirect_ctrl_if.sv - request/grant bundle between main control and the PC redirect controller
interface pc_redirect_ctrl_if;
  logic       stall;
  logic       seq_req;
  logic       br_req;
  logic [1:0] br_type;
  logic       alu_zero;
  logic       alu_neg;
  logic       jmp_req;
  logic       jr_req;
  logic       exc_req;
  logic       exc_code;
  logic [3:0] pc_source;
  logic       pc_write;
  logic       epc_write;
  logic       cause_write;
  logic       cause;
  logic       seq_ack;
  logic       br_ack;
  logic       jmp_ack;
  logic       exc_ack;
  logic       br_taken;

  // Main control side: raises requests, consumes grants and PC strobes
  modport master (
    output stall, seq_req, br_req, br_type, alu_zero, alu_neg,
           jmp_req, jr_req, exc_req, exc_code,
    input  pc_source, pc_write, epc_write, cause_write, cause,
           seq_ack, br_ack, jmp_ack, exc_ack, br_taken
  );

  // Controller side
  modport slave (
    input  stall, seq_req, br_req, br_type, alu_zero, alu_neg,
           jmp_req, jr_req, exc_req, exc_code,
    output pc_source, pc_write, epc_write, cause_write, cause,
           seq_ack, br_ack, jmp_ack, exc_ack, br_taken
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - PC-source sequencing, redirect arbitration and exception entry
module pc_redirect_ctrl (
  input  logic             clk,
  input  logic             reset_n,
  pc_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    EXC_SAVE   = 2'd2,
    EXC_VECTOR = 2'd3
  } state_t;

  localparam logic [3:0] SRC_ALU    = 4'b0000;
  localparam logic [3:0] SRC_EXCVEC = 4'b0001;
  localparam logic [3:0] SRC_BRANCH = 4'b0010;
  localparam logic [3:0] SRC_JUMP   = 4'b0011;

  state_t     state_q, state_d;
  logic [3:0] pc_source_q, pc_source_d;
  logic       pc_write_q, pc_write_d;
  logic       epc_write_q, epc_write_d;
  logic       cause_write_q, cause_write_d;
  logic       cause_q, cause_d;
  logic       seq_ack_q, seq_ack_d;
  logic       br_ack_q, br_ack_d;
  logic       jmp_ack_q, jmp_ack_d;
  logic       exc_ack_q, exc_ack_d;
  logic       br_taken_q, br_taken_d;
  logic       br_cond;

  // Branch condition from ALU flags, evaluated combinationally and captured at the grant edge
  always_comb begin
    br_cond = 1'b0;
    case (bus.br_type)
      2'b00:   br_cond = bus.alu_zero;
      2'b01:   br_cond = !bus.alu_zero;
      2'b10:   br_cond = bus.alu_zero | bus.alu_neg;
      default: br_cond = !bus.alu_zero & !bus.alu_neg;
    endcase
  end

  // Next state and next registered outputs; strobes default low so every state is one-shot
  always_comb begin
    state_d       = state_q;
    pc_source_d   = SRC_ALU;
    pc_write_d    = 1'b0;
    epc_write_d   = 1'b0;
    cause_write_d = 1'b0;
    cause_d       = cause_q;
    seq_ack_d     = 1'b0;
    br_ack_d      = 1'b0;
    jmp_ack_d     = 1'b0;
    exc_ack_d     = 1'b0;
    br_taken_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.stall) begin
          if (bus.exc_req) begin
            state_d       = EXC_SAVE;
            epc_write_d   = 1'b1;
            cause_write_d = 1'b1;
            exc_ack_d     = 1'b1;
            cause_d       = bus.exc_code;
          end else if (bus.jr_req) begin
            state_d     = ISSUE;
            jmp_ack_d   = 1'b1;
            pc_source_d = SRC_ALU;
            pc_write_d  = 1'b1;
          end else if (bus.jmp_req) begin
            state_d     = ISSUE;
            jmp_ack_d   = 1'b1;
            pc_source_d = SRC_JUMP;
            pc_write_d  = 1'b1;
          end else if (bus.br_req) begin
            state_d     = ISSUE;
            br_ack_d    = 1'b1;
            pc_source_d = SRC_BRANCH;
            br_taken_d  = br_cond;
            pc_write_d  = br_cond;
          end else if (bus.seq_req) begin
            state_d     = ISSUE;
            seq_ack_d   = 1'b1;
            pc_source_d = SRC_ALU;
            pc_write_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = IDLE;
      end
      EXC_SAVE: begin
        state_d     = EXC_VECTOR;
        pc_source_d = SRC_EXCVEC;
        pc_write_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight exception entry
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_source_q   <= SRC_ALU;
      pc_write_q    <= 1'b0;
      epc_write_q   <= 1'b0;
      cause_write_q <= 1'b0;
      cause_q       <= 1'b0;
      seq_ack_q     <= 1'b0;
      br_ack_q      <= 1'b0;
      jmp_ack_q     <= 1'b0;
      exc_ack_q     <= 1'b0;
      br_taken_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_source_q   <= pc_source_d;
      pc_write_q    <= pc_write_d;
      epc_write_q   <= epc_write_d;
      cause_write_q <= cause_write_d;
      cause_q       <= cause_d;
      seq_ack_q     <= seq_ack_d;
      br_ack_q      <= br_ack_d;
      jmp_ack_q     <= jmp_ack_d;
      exc_ack_q     <= exc_ack_d;
      br_taken_q    <= br_taken_d;
    end
  end

  assign bus.pc_source   = pc_source_q;
  assign bus.pc_write    = pc_write_q;
  assign bus.epc_write   = epc_write_q;
  assign bus.cause_write = cause_write_q;
  assign bus.cause       = cause_q;
  assign bus.seq_ack     = seq_ack_q;
  assign bus.br_ack      = br_ack_q;
  assign bus.jmp_ack     = jmp_ack_q;
  assign bus.exc_ack     = exc_ack_q;
  assign bus.br_taken    = br_taken_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  pc_redirect_ctrl_if bus ();

  pc_redirect_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {pc_source, pc_write, epc_write, cause_write, cause, seq_ack, br_ack, jmp_ack, exc_ack, br_taken}
  function automatic logic [12:0] pk(logic [3:0] src, logic pw, logic ew, logic cw, logic c,
                                     logic sa, logic ba, logic ja, logic ea, logic bt);
    return {src, pw, ew, cw, c, sa, ba, ja, ea, bt};
  endfunction

  function automatic logic [12:0] observed();
    return pk(bus.pc_source, bus.pc_write, bus.epc_write, bus.cause_write, bus.cause,
              bus.seq_ack, bus.br_ack, bus.jmp_ack, bus.exc_ack, bus.br_taken);
  endfunction

  task automatic check_eq(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    bus.stall    = 1'b0;
    bus.seq_req  = 1'b0;
    bus.br_req   = 1'b0;
    bus.br_type  = 2'b00;
    bus.alu_zero = 1'b0;
    bus.alu_neg  = 1'b0;
    bus.jmp_req  = 1'b0;
    bus.jr_req   = 1'b0;
    bus.exc_req  = 1'b0;
    bus.exc_code = 1'b0;
  endtask

  logic [12:0] zero0;
  logic [12:0] zero1;

  initial begin
    checks  = 0;
    errors  = 0;
    zero0   = pk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    zero1   = pk(4'b0000, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    clear_reqs();
    step();
    step();
    check_eq("reset_state", observed(), zero0);
    reset_n = 1'b1;

    // Sequential fetch
    bus.seq_req = 1'b1;
    step();
    check_eq("seq_issue", observed(), pk(4'b0000, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    bus.seq_req = 1'b0;
    step();
    check_eq("seq_after", observed(), zero0);

    // BNE with zero set: not taken, still acked
    bus.br_req = 1'b1; bus.br_type = 2'b01; bus.alu_zero = 1'b1;
    step();
    check_eq("bne_not_taken", observed(), pk(4'b0010, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    bus.br_req = 1'b0;
    step();
    check_eq("bne_after", observed(), zero0);

    // BEQ with zero set: taken
    bus.br_req = 1'b1; bus.br_type = 2'b00; bus.alu_zero = 1'b1;
    step();
    check_eq("beq_taken", observed(), pk(4'b0010, 1, 0, 0, 0, 0, 1, 0, 0, 1));
    bus.br_req = 1'b0;
    step();

    // BGT with neg set: not taken
    bus.br_req = 1'b1; bus.br_type = 2'b11; bus.alu_zero = 1'b0; bus.alu_neg = 1'b1;
    step();
    check_eq("bgt_not_taken", observed(), pk(4'b0010, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    bus.br_req = 1'b0;
    step();

    // BLE with neg set: taken
    bus.br_req = 1'b1; bus.br_type = 2'b10;
    step();
    check_eq("ble_taken", observed(), pk(4'b0010, 1, 0, 0, 0, 0, 1, 0, 0, 1));
    bus.br_req = 1'b0;
    bus.alu_neg = 1'b0;
    step();
    check_eq("ble_after", observed(), zero0);

    // Priority: exc beats jmp beats seq, exception runs save then vector
    bus.exc_req = 1'b1; bus.exc_code = 1'b1; bus.jmp_req = 1'b1; bus.seq_req = 1'b1;
    step();
    check_eq("exc_save", observed(), pk(4'b0000, 0, 1, 1, 1, 0, 0, 0, 1, 0));
    bus.exc_req = 1'b0; bus.exc_code = 1'b0;
    step();
    check_eq("exc_vector", observed(), pk(4'b0001, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    step();
    check_eq("exc_back_idle", observed(), zero1);
    step();
    check_eq("jmp_after_exc", observed(), pk(4'b0011, 1, 0, 0, 1, 0, 0, 1, 0, 0));
    bus.jmp_req = 1'b0;
    step();
    check_eq("seq_not_in_issue", observed(), zero1);
    step();
    check_eq("seq_after_jmp", observed(), pk(4'b0000, 1, 0, 0, 1, 1, 0, 0, 0, 0));
    bus.seq_req = 1'b0;
    step();

    // Stall hold with JR pending
    bus.stall = 1'b1; bus.jr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("stall_hold%0d", i), observed(), zero1);
    end
    bus.stall = 1'b0;
    step();
    check_eq("jr_after_stall", observed(), pk(4'b0000, 1, 0, 0, 1, 0, 0, 1, 0, 0));
    bus.jr_req = 1'b0;
    step();

    // Late request raised during a jump issue
    bus.jmp_req = 1'b1;
    step();
    check_eq("late_jmp", observed(), pk(4'b0011, 1, 0, 0, 1, 0, 0, 1, 0, 0));
    bus.jmp_req = 1'b0; bus.seq_req = 1'b1;
    step();
    check_eq("late_gap", observed(), zero1);
    step();
    check_eq("late_seq", observed(), pk(4'b0000, 1, 0, 0, 1, 1, 0, 0, 0, 0));
    bus.seq_req = 1'b0;
    step();

    // Overflow exception updates cause to 0
    bus.exc_req = 1'b1; bus.exc_code = 1'b0;
    step();
    check_eq("exc0_save", observed(), pk(4'b0000, 0, 1, 1, 0, 0, 0, 0, 1, 0));
    bus.exc_req = 1'b0;
    step();
    check_eq("exc0_vector", observed(), pk(4'b0001, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    step();

    // Reset during EXC_SAVE: vector never issued
    bus.exc_req = 1'b1; bus.exc_code = 1'b1;
    step();
    check_eq("rst_exc_save", observed(), pk(4'b0000, 0, 1, 1, 1, 0, 0, 0, 1, 0));
    bus.exc_req = 1'b0;
    reset_n = 1'b0;
    step();
    check_eq("rst_mid_exc", observed(), zero0);
    reset_n = 1'b1;
    step();
    check_eq("rst_no_vector", observed(), zero0);
    step();
    check_eq("rst_idle", observed(), zero0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequencing controller for the multicycle PC-source selection path. It drives the 4-bit PC-source selector and the PC write enable. It arbitrates concurrent redirect requests from the main control unit (sequential fetch, branch, jump, jump-register, exception), evaluates branch conditions from ALU flags, and runs the two-step exception entry that saves EPC/Cause before vectoring. It sits between the main control FSM and the PC register / PC-source mux.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `stall`  in  1  memory wait; holds the FSM in IDLE (no grants).
- `seq_req`  in  1  request PC <= PC+4 (ALU result).
- `br_req`  in  1  conditional branch request.
- `br_type`  in  2  00 BEQ, 01 BNE, 10 BLE, 11 BGT.
- `alu_zero`  in  1  ALU zero flag for branch compare.
- `alu_neg`  in  1  ALU negative flag for branch compare.
- `jmp_req`  in  1  J/JAL request, target from jump-target input.
- `jr_req`  in  1  JR request, target is ALU result (rs passthrough).
- `exc_req`  in  1  exception request.
- `exc_code`  in  1  0 overflow, 1 invalid opcode.
- `pc_source`  out  4  selector: 0000 ALU result, 0001 exception vector 32'd4, 0010 branch target (ALUOut), 0011 jump target.
- `pc_write`  out  1  PC load enable.
- `epc_write`  out  1  EPC load enable.
- `cause_write`  out  1  Cause register load enable.
- `cause`  out  1  registered `exc_code`.
- `seq_ack`, `br_ack`, `jmp_ack`, `exc_ack`  out  1 each  one-cycle grant pulses. `jmp_ack` covers both J and JR.
- `br_taken`  out  1  registered branch decision, valid with `br_ack`.

## Operation
- All outputs are registered. Reset value of every output is 0, including `pc_source` = 0000. The FSM resets to IDLE.
- FSM states: IDLE, ISSUE, EXC_SAVE, EXC_VECTOR.
- IDLE: if `stall`=1 or no request is pending, stay in IDLE with all strobes 0 and `pc_source` = 0000.
- Otherwise, grant exactly one request by fixed priority: exc > jr > jmp > br > seq.
  - exc wins: go to EXC_SAVE.
  - Any other winner: go to ISSUE.
- Losing requests are not acked. Requesters hold them high until acked.
- ISSUE (1 cycle): assert the winner's ack, then return to IDLE.
  - seq: `pc_source` = 0000, `pc_write` = 1.
  - jr: 0000, `pc_write` = 1.
  - jmp: 0011, `pc_write` = 1.
  - br: 0010, `pc_write` = `br_taken`.
- Branch condition is sampled at the grant edge:
  - BEQ: `alu_zero`.
  - BNE: `!alu_zero`.
  - BLE: `alu_zero | alu_neg`.
  - BGT: `!alu_zero & !alu_neg`.
- A not-taken branch still produces `br_ack` = 1. `pc_write` stays 0 and `pc_source` = 0010.
- EXC_SAVE (1 cycle): `epc_write` = 1, `cause_write` = 1, `cause` = `exc_code` as sampled at grant, `exc_ack` = 1. Go to EXC_VECTOR.
- EXC_VECTOR (1 cycle): `pc_source` = 0001, `pc_write` = 1. Go to IDLE.
- `cause` holds its value until the next exception grant.
- `stall` is ignored outside IDLE. ISSUE, EXC_SAVE and EXC_VECTOR always complete.
- Requests (including a new `exc_req`) arriving outside IDLE are not sampled. They are evaluated on the first IDLE cycle.

## Timing
- Grant decision at edge N (FSM in IDLE, `stall`=0). Outputs for a non-exception grant are valid during cycle N→N+1. The PC loads at edge N+1.
- Exception timing: save strobes in cycle N→N+1, vector strobes in cycle N+1→N+2, PC = 4 after edge N+2.
- Minimum spacing between grants is 2 cycles for normal grants and 3 cycles for exceptions.
- Requesters must deassert in the cycle their ack is high. A request still high on the next IDLE edge is treated as a new request.
- `reset_n` = 0 at any edge, in any state: next state is IDLE, all outputs 0 in the following cycle, and pending decisions are discarded.
  - In EXC_SAVE, EXC_VECTOR is never reached.
- Simultaneous requests with `stall` = 1: nothing is granted. On the first edge with `stall` = 0, the highest-priority request wins.

## Test plan
- **Reset mid-exception:** assert `exc_req`, then pull `reset_n` = 0 during EXC_SAVE.
  - Next cycle: all outputs 0, state IDLE.
  - `pc_write` never pulses with 0001.
- **Sequential request:** `seq_req` alone at edge N.
  - Cycle N+1: `pc_write` = 1, `pc_source` = 0000, `seq_ack` = 1.
  - Cycle N+2: all strobes 0.
- **Branches:**
  - BNE with `alu_zero` = 1: `br_ack` = 1, `br_taken` = 0, `pc_write` = 0.
  - BEQ with `alu_zero` = 1: `pc_write` = 1, `pc_source` = 0010.
  - BGT with `alu_neg` = 1: `pc_write` = 0.
- **Priority and exception sequence:** `exc_req` (`exc_code` = 1), `jmp_req` and `seq_req` all high at N.
  - N+1: `epc_write` = `cause_write` = `exc_ack` = 1, `cause` = 1.
  - N+2: `pc_source` = 0001, `pc_write` = 1.
  - Then `jmp_ack` with `pc_source` = 0011.
  - Then `seq_ack`.
- **Stall hold:** `stall` = 1 for 3 cycles with `jr_req` high.
  - No strobes while stalled.
  - One cycle after `stall` falls: `jmp_ack` = 1, `pc_source` = 0000, `pc_write` = 1.
- **Late request:** `seq_req` high during ISSUE of a jump. It is granted only on the following IDLE edge, with no ack overlap.
